// File: rtl/decode_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage_pipe
// Purpose  : Handshaked 32-bit decode stage with an output pipeline register,
//            memsync drain / syscall serialisation FSM and pipeline flush.
// Revision : 1.0 - initial release
// ============================================================================
module decode_stage_pipe #(
  parameter int PC_W           = 32,
  parameter int IMM_W          = 21,
  parameter int SYNC_DRAIN     = 5,
  parameter int SYSCALL_SERIAL = 1
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic              flush_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       insn_in,
  input  logic [PC_W-1:0]   insn_pc_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4:0]        rsa_out,
  output logic [4:0]        rsb_out,
  output logic [4:0]        rd_out,
  output logic [4:0]        reg_select_out,
  output logic [IMM_W-1:0]  imm_out,
  output logic [3:0]        aluop_out,
  output logic [1:0]        branch_funct_out,
  output logic              jlnk_out,
  output logic              pc_change_rel_out,
  output logic              pc_change_abs_out,
  output logic              mem_read_out,
  output logic              mem_write_out,
  output logic              memsync_out,
  output logic              syscall_out,
  output logic [31:0]       cp_insn_out,
  output logic [PC_W-1:0]   insn_pc_out
);

  localparam int CNT_W = (SYNC_DRAIN > 1) ? $clog2(SYNC_DRAIN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYNC_DRAIN - 1);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_SYNC   = 2'd1,
    ST_SERIAL = 2'd2
  } state_t;

  typedef struct packed {
    logic [4:0]       rsa;
    logic [4:0]       rsb;
    logic [4:0]       rd;
    logic [4:0]       reg_sel;
    logic [IMM_W-1:0] imm;
    logic [3:0]       aluop;
    logic [1:0]       bfunct;
    logic             jlnk;
    logic             rel;
    logic             abs_chg;
    logic             mem_rd;
    logic             mem_wr;
    logic             msync;
    logic             sysc;
    logic [31:0]      cp;
    logic [PC_W-1:0]  pc;
  } bundle_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  bundle_t          bundle_q, bundle_d;
  bundle_t          dec;

  logic [5:0] op;
  logic [7:0] funct_sys;
  logic is_int, is_imm, is_li, is_br, is_jmp, is_jlnk, is_ld, is_st, is_sys, known;
  logic use_rd, use_rsa, use_rsb, pc_chg, accept;

  assign op        = insn_in[31:26];
  assign funct_sys = insn_in[15:8];
  assign is_int    = (op == 6'b010011);
  assign is_imm    = (op == 6'b010110);
  assign is_li     = (op == 6'b010000);
  assign is_br     = (op == 6'b001101);
  assign is_jmp    = (op == 6'b001100);
  assign is_jlnk   = (op == 6'b000100);
  assign is_ld     = (op == 6'b011110);
  assign is_st     = (op == 6'b011101);
  assign is_sys    = (op == 6'b110000);
  assign known     = is_int | is_imm | is_li | is_br | is_jmp | is_jlnk | is_ld | is_st | is_sys;

  assign use_rd  = (op[1] | op[0]) & (~op[2] | op[1]);
  assign use_rsa = op[2] | op[1];
  assign use_rsb = (op[2] & op[0]) | (op[1] & op[0]);
  // Unknown opcodes must not raise any control, so the PC-change term is gated.
  assign pc_chg  = known & ~op[4];

  always_comb begin
    dec         = '0;
    dec.rd      = use_rd  ? insn_in[25:21] : 5'd0;
    dec.rsa     = use_rsa ? insn_in[20:16] : 5'd0;
    dec.rsb     = use_rsb ? insn_in[15:11] : 5'd0;
    dec.imm     = '0;
    if (is_imm)                  dec.imm = IMM_W'(insn_in[15:4]);
    else if (is_ld || is_st)     dec.imm = IMM_W'(insn_in[13:0]);
    else if (is_li)              dec.imm = IMM_W'(insn_in[15:0]);
    else if (is_jmp || is_jlnk)  dec.imm = IMM_W'({insn_in[25:21], insn_in[15:0]});
    else if (is_br)              dec.imm = IMM_W'({insn_in[25:21], insn_in[10:2]});
    else if (is_sys)             dec.imm = IMM_W'(insn_in[7:0]);
    dec.rel     = pc_chg & (is_jmp | is_jlnk | (insn_in[20:16] == 5'd0));
    dec.abs_chg = pc_chg & ~dec.rel;
    dec.jlnk    = is_jlnk;
    dec.mem_wr  = known & op[4] & op[3] & use_rsb;
    dec.mem_rd  = known & op[4] & op[3] & ~use_rsb;
    if (is_int || is_imm) dec.aluop = insn_in[3:0];
    else if (dec.rel)     dec.aluop = 4'b0000;
    else if (is_br)       dec.aluop = 4'b1100;
    else                  dec.aluop = 4'b1111;
    dec.bfunct  = is_br ? insn_in[1:0] : 2'b00;
    if (is_li)                       dec.reg_sel = insn_in[20:16];
    else if (is_sys && funct_sys[1]) dec.reg_sel = 5'b10000;
    dec.sysc    = is_sys & (funct_sys == 8'h00);
    dec.msync   = is_sys & (funct_sys == 8'h04);
    dec.cp      = op[5] ? insn_in : 32'd0;
    dec.pc      = insn_pc_in;
  end

  assign in_ready = (state_q == ST_RUN) & ~reset_in & ~flush_in & (~out_valid_q | out_ready);
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    bundle_d    = bundle_q;
    if (flush_in) begin
      out_valid_d = 1'b0;
      state_d     = ST_RUN;
      cnt_d       = '0;
    end else begin
      if (accept) begin
        bundle_d    = dec;
        out_valid_d = 1'b1;
      end else if (out_ready) begin
        out_valid_d = 1'b0;
      end
      case (state_q)
        ST_RUN: begin
          if (accept && dec.msync) begin
            state_d = ST_SYNC;
            cnt_d   = '0;
          end else if (accept && dec.sysc && (SYSCALL_SERIAL == 1)) begin
            state_d = ST_SERIAL;
          end
        end
        ST_SYNC: begin
          if (cnt_q == CNT_LAST) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_SERIAL: begin
          if (out_valid_q && out_ready) state_d = ST_RUN;
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q     <= ST_RUN;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      bundle_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      bundle_q    <= bundle_d;
    end
  end

  assign out_valid         = out_valid_q;
  assign rsa_out           = bundle_q.rsa;
  assign rsb_out           = bundle_q.rsb;
  assign rd_out            = bundle_q.rd;
  assign reg_select_out    = bundle_q.reg_sel;
  assign imm_out           = bundle_q.imm;
  assign aluop_out         = bundle_q.aluop;
  assign branch_funct_out  = bundle_q.bfunct;
  assign jlnk_out          = bundle_q.jlnk;
  assign pc_change_rel_out = bundle_q.rel;
  assign pc_change_abs_out = bundle_q.abs_chg;
  assign mem_read_out      = bundle_q.mem_rd;
  assign mem_write_out     = bundle_q.mem_wr;
  assign memsync_out       = bundle_q.msync;
  assign syscall_out       = bundle_q.sysc;
  assign cp_insn_out       = bundle_q.cp;
  assign insn_pc_out       = bundle_q.pc;

endmodule
`default_nettype wire
